// File: rtl/sdpram_fifo_pkg.sv
// sdpram_fifo_pkg: sizing helpers shared by the FWFT FIFO controller.
// cnt_w: width of the used/peak counters; cap_f: total words the FIFO can
// hold (RAM plus in-flight reads plus output buffer); buf_d: output buffer depth.
package sdpram_fifo_pkg;
  function automatic int cnt_w(input int ram_deep);
    return ram_deep + 2;
  endfunction
  function automatic int cap_f(input int ram_deep, input int r_latency);
    return (1 << ram_deep) + r_latency + 1;
  endfunction
  function automatic int buf_d(input int r_latency);
    return r_latency + 1;
  endfunction
endpackage

// File: rtl/sdpram_fifo_ctrl_sdpram.sv
// sdpram: simple dual-port RAM, one write port and one read port with R_LATENCY-cycle read data.
// Ports: clk_wr/wren/wraddress/data write side; clk_rd/rden/rdaddress/q read side.
module sdpram #(
  parameter int RAM_DEEP  = 10,
  parameter int RAM_WIDTH = 8,
  parameter int R_LATENCY = 1
) (
  input  logic                 clk_wr,
  input  logic                 wren,
  input  logic [RAM_DEEP-1:0]  wraddress,
  input  logic [RAM_WIDTH-1:0] data,
  input  logic                 clk_rd,
  input  logic                 rden,
  input  logic [RAM_DEEP-1:0]  rdaddress,
  output logic [RAM_WIDTH-1:0] q
);
  logic [RAM_WIDTH-1:0] mem [2**RAM_DEEP];
  logic [RAM_WIDTH-1:0] q_pipe [R_LATENCY];
  always_ff @(posedge clk_wr)
    if (wren) mem[wraddress] <= data;
  always_ff @(posedge clk_rd) begin
    if (rden) q_pipe[0] <= mem[rdaddress];
    for (int i = 1; i < R_LATENCY; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign q = q_pipe[R_LATENCY-1];
endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// sdpram_fifo_ctrl: first-word-fall-through FIFO sequencing one sdpram instance.
// Ports: clk, reset (async, active-high), flush (sync clear); write stream
// in_valid/in_ready/in_data; read stream out_valid/out_ready/out_data;
// used_cnt (RAM + in-flight + buffered words), almost_full (used_cnt >= AFULL_TH).
// Define SDPRAM_FIFO_STAT_EN to add sticky ovf_err/udf_err and peak_cnt.
module sdpram_fifo_ctrl import sdpram_fifo_pkg::*; #(
  parameter int RAM_DEEP  = 10,
  parameter int RAM_WIDTH = 8,
  parameter int R_LATENCY = 1,
  parameter int AFULL_TH  = 2**RAM_DEEP - 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RAM_WIDTH-1:0]       in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RAM_WIDTH-1:0]       out_data,
  output logic [cnt_w(RAM_DEEP)-1:0] used_cnt,
  output logic                       almost_full
`ifdef SDPRAM_FIFO_STAT_EN
  ,
  output logic                       ovf_err,
  output logic                       udf_err,
  output logic [cnt_w(RAM_DEEP)-1:0] peak_cnt
`endif
);
  localparam int CW    = cnt_w(RAM_DEEP);
  localparam int CAP   = cap_f(RAM_DEEP, R_LATENCY);
  localparam int DEPTH = CAP - R_LATENCY - 1;
  localparam int BD    = buf_d(R_LATENCY);
  localparam int BIW   = $clog2(BD);
  localparam int BW    = $clog2(BD + 1);
  logic [RAM_DEEP-1:0]  wr_ptr, rd_ptr;
  logic [RAM_DEEP:0]    ram_cnt, ram_cnt_n;
  logic [R_LATENCY-1:0] pipe;
  logic [BW-1:0]        infl, infl_n, buf_cnt, buf_n;
  logic [BIW-1:0]       bh, bt;
  logic [RAM_WIDTH-1:0] bmem [BD];
  logic [RAM_WIDTH-1:0] q;
  logic [CW-1:0]        used_n;
  logic                 push, pop, rden, cap;
  function automatic logic [BIW-1:0] bnext(input logic [BIW-1:0] x);
    return (x == BIW'(BD - 1)) ? '0 : x + BIW'(1);
  endfunction
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign cap       = pipe[R_LATENCY-1];
  assign out_valid = buf_cnt != '0;
  assign out_data  = bmem[bh];
  // Issue a read only if its word is guaranteed a buffer slot on arrival;
  // counting this cycle's pop keeps the stream at one word per cycle.
  // ram_cnt is registered, so a word written this cycle is never visible here.
  assign rden = !flush && ram_cnt != '0 && (int'(infl) + int'(buf_cnt) < BD + int'(pop));
  always_comb begin
    ram_cnt_n = ram_cnt + (RAM_DEEP+1)'(push) - (RAM_DEEP+1)'(rden);
    infl_n    = infl + BW'(rden) - BW'(cap);
    buf_n     = buf_cnt + BW'(cap) - BW'(pop);
    used_n    = flush ? '0 : CW'(ram_cnt_n) + CW'(infl_n) + CW'(buf_n);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      pipe        <= '0;
      infl        <= '0;
      buf_cnt     <= '0;
      bh          <= '0;
      bt          <= '0;
      used_cnt    <= '0;
      almost_full <= 1'b0;
      in_ready    <= 1'b0;
      for (int i = 0; i < BD; i++) bmem[i] <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      pipe        <= '0;
      infl        <= '0;
      buf_cnt     <= '0;
      bh          <= '0;
      bt          <= '0;
      used_cnt    <= '0;
      almost_full <= AFULL_TH <= 0;
      in_ready    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + RAM_DEEP'(1);
      if (rden) rd_ptr <= rd_ptr + RAM_DEEP'(1);
      if (cap) begin
        bmem[bt] <= q;
        bt       <= bnext(bt);
      end
      if (pop) bh <= bnext(bh);
      ram_cnt     <= ram_cnt_n;
      pipe        <= R_LATENCY'({pipe, rden});
      infl        <= infl_n;
      buf_cnt     <= buf_n;
      used_cnt    <= used_n;
      almost_full <= int'(used_n) >= AFULL_TH;
      in_ready    <= int'(ram_cnt_n) < DEPTH;
    end
`ifdef SDPRAM_FIFO_STAT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ovf_err  <= 1'b0;
      udf_err  <= 1'b0;
      peak_cnt <= '0;
    end else if (flush) begin
      ovf_err  <= 1'b0;
      udf_err  <= 1'b0;
      peak_cnt <= '0;
    end else begin
      ovf_err  <= ovf_err || (in_valid && !in_ready);
      udf_err  <= udf_err || (out_ready && !out_valid);
      peak_cnt <= (used_n > peak_cnt) ? used_n : peak_cnt;
    end
`endif
  sdpram #(
    .RAM_DEEP (RAM_DEEP),
    .RAM_WIDTH(RAM_WIDTH),
    .R_LATENCY(R_LATENCY)
  ) u_ram (
    .clk_wr   (clk),
    .wren     (push),
    .wraddress(wr_ptr),
    .data     (in_data),
    .clk_rd   (clk),
    .rden     (rden),
    .rdaddress(rd_ptr),
    .q        (q)
  );
endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// tb_sdpram_fifo_ctrl: scoreboard bench for two FIFO configurations (depth 4/latency 1, depth 8/latency 2).
module tb_sdpram_fifo_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic iv0 = 0, fl0 = 0, or0 = 0, rdy0, ov0, af0;
  logic [7:0] id0 = 0, od0;
  logic [3:0] used0;
  logic iv1 = 0, fl1 = 0, or1 = 0, rdy1, ov1, af1;
  logic [7:0] id1 = 0, od1;
  logic [4:0] used1;
`ifdef SDPRAM_FIFO_STAT_EN
  logic ovf0, udf0, ovf1, udf1;
  logic [3:0] peak0;
  logic [4:0] peak1;
`endif
  logic [7:0] q0[$], q1[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  sdpram_fifo_ctrl #(.RAM_DEEP(2), .RAM_WIDTH(8), .R_LATENCY(1), .AFULL_TH(5)) u0 (
    .clk(clk), .reset(reset), .flush(fl0), .in_valid(iv0), .in_ready(rdy0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .used_cnt(used0), .almost_full(af0)
`ifdef SDPRAM_FIFO_STAT_EN
    , .ovf_err(ovf0), .udf_err(udf0), .peak_cnt(peak0)
`endif
  );
  sdpram_fifo_ctrl #(.RAM_DEEP(3), .RAM_WIDTH(8), .R_LATENCY(2)) u1 (
    .clk(clk), .reset(reset), .flush(fl1), .in_valid(iv1), .in_ready(rdy1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .used_cnt(used1), .almost_full(af1)
`ifdef SDPRAM_FIFO_STAT_EN
    , .ovf_err(ovf1), .udf_err(udf1), .peak_cnt(peak1)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic c0(input logic iv, input logic [7:0] d, input logic r, input logic f);
    @(negedge clk);
    iv0 = iv; id0 = d; or0 = r; fl0 = f;
    chk("used0", 32'(used0), q0.size());
    chk("af0", 32'(af0), 32'(q0.size() >= 5));
    if (f) q0.delete();
    else begin
      if (ov0 && r) begin
        if (q0.size() == 0) chk("spurious0", 32'(ov0), 0);
        else chk("data0", 32'(od0), 32'(q0.pop_front()));
      end
      if (iv && rdy0) q0.push_back(d);
    end
  endtask
  task automatic c1(input logic iv, input logic [7:0] d, input logic r, input logic f);
    @(negedge clk);
    iv1 = iv; id1 = d; or1 = r; fl1 = f;
    chk("used1", 32'(used1), q1.size());
    chk("af1", 32'(af1), 32'(q1.size() >= 4));
    if (f) q1.delete();
    else begin
      if (ov1 && r) begin
        if (q1.size() == 0) chk("spurious1", 32'(ov1), 0);
        else chk("data1", 32'(od1), 32'(q1.pop_front()));
      end
      if (iv && rdy1) q1.push_back(d);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int acc, gaps, stalls;
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy0), 0);
    chk("rst_ov", 32'(ov0), 0);
    chk("rst_data", 32'(od0), 0);
    chk("rst_used", 32'(used0), 0);
    chk("rst_af", 32'(af0), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_release", 32'(rdy0), 1);
    c0(1, 8'hA5, 0, 0);
    c0(0, 0, 0, 0);
    chk("lat_c1_ov", 32'(ov0), 0);
    chk("lat_c1_used", 32'(used0), 1);
    c0(0, 0, 0, 0);
    chk("lat_c2_ov", 32'(ov0), 0);
    c0(0, 0, 1, 0);
    chk("lat_c3_ov", 32'(ov0), 1);
    chk("lat_c3_data", 32'(od0), 32'h A5);
    c0(0, 0, 0, 0);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      c0(1, 8'(i), 0, 0);
      if (rdy0) acc++;
    end
    c0(0, 0, 0, 0);
    chk("cap_accepted", acc, 6);
    chk("cap_used", 32'(used0), 6);
    chk("cap_rdy", 32'(rdy0), 0);
    chk("cap_af", 32'(af0), 1);
`ifdef SDPRAM_FIFO_STAT_EN
    chk("ovf_set", 32'(ovf0), 1);
    chk("udf_clear", 32'(udf0), 0);
    chk("peak", 32'(peak0), 6);
`endif
    repeat (8) c0(0, 0, 1, 0);
    c0(0, 0, 0, 0);
    chk("drain_used", 32'(used0), 0);
`ifdef SDPRAM_FIFO_STAT_EN
    chk("ovf_sticky", 32'(ovf0), 1);
    chk("udf_set", 32'(udf0), 1);
    c0(0, 0, 0, 1);
    c0(0, 0, 0, 0);
    chk("ovf_flush", 32'(ovf0), 0);
    chk("udf_flush", 32'(udf0), 0);
    chk("peak_flush", 32'(peak0), 0);
`endif
    gaps = 0; stalls = 0; seen = 0;
    for (int i = 0; i < 1000; i++) begin
      c1(1, 8'(i * 7 + 3), 1, 0);
      if (!rdy1) stalls++;
      if (ov1) seen = 1;
      else if (seen) gaps++;
    end
    chk("thr_gaps", gaps, 0);
    chk("thr_stalls", stalls, 0);
    repeat (12) c1(0, 0, 1, 0);
    chk("thr_empty", 32'(used1), 0);
    for (int i = 0; i < 600; i++)
      c1(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0);
    repeat (20) c1(0, 0, 1, 0);
    c1(0, 0, 0, 0);
    chk("rand_empty", 32'(used1), 0);
    c1(1, 8'h21, 0, 0);
    c1(1, 8'h22, 0, 0);
    c1(1, 8'h23, 0, 0);
    c1(0, 0, 0, 1);
    c1(0, 0, 0, 0);
    chk("flush_ov", 32'(ov1), 0);
    chk("flush_used", 32'(used1), 0);
    for (int i = 0; i < 4; i++) begin
      c1(0, 0, 0, 0);
      chk("flush_stale", 32'(ov1), 0);
    end
    c1(1, 8'h11, 0, 0);
    repeat (3) c1(0, 0, 0, 0);
    c1(0, 0, 1, 0);
    chk("flush_ov11", 32'(ov1), 1);
    chk("flush_data11", 32'(od1), 32'h11);
    c1(0, 0, 0, 0);
    c0(1, 8'h31, 0, 0);
    c0(1, 8'h32, 0, 0);
    c0(1, 8'h33, 0, 0);
    c1(1, 8'h41, 0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_rdy", 32'(rdy0), 0);
    chk("arst_ov", 32'(ov0), 0);
    chk("arst_data", 32'(od0), 0);
    chk("arst_used", 32'(used0), 0);
    chk("arst_af", 32'(af0), 0);
    chk("arst_used1", 32'(used1), 0);
    q0.delete(); q1.delete();
    iv0 = 0; iv1 = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_rdy_rel", 32'(rdy0), 1);
    c0(1, 8'h5A, 0, 0);
    repeat (2) c0(0, 0, 0, 0);
    c0(0, 0, 1, 0);
    chk("arst_ov_rec", 32'(ov0), 1);
    c0(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
